// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M shift-add multiply sequencer.
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int              CNT_W    = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_RUN,
    ST_NEG_LO,
    ST_NEG_HI,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit carry-lookahead adder: per-bit propagate/generate/sum cells with a
// parallel-prefix carry tree. Carry-in is folded into bit 0's generate term.
module cla_adder_32
  import mul_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cin,
  output logic [XLEN-1:0] sum,
  output logic            cout
);

  logic [XLEN-1:0] p;
  logic [XLEN-1:0] g;
  logic [XLEN-1:0] c_out_bit;

  // Bit cells: propagate and generate, with cin merged into bit 0.
  always_comb begin
    p = a ^ b;
    g = (a & b) | {{(XLEN-1){1'b0}}, p[0] & cin};
  end

  // Lookahead tree: after log2(XLEN) levels each bit holds its carry-out.
  always_comb begin
    logic [XLEN-1:0] gg;
    logic [XLEN-1:0] pp;
    gg = g;
    pp = p;
    for (int l = 0; l < 5; l++) begin
      gg = gg | (pp & (gg << (1 << l)));
      pp = pp & (pp << (1 << l));
    end
    c_out_bit = gg;
  end

  // Sum cells and final carry.
  always_comb begin
    sum  = p ^ {c_out_bit[XLEN-2:0], cin};
    cout = c_out_bit[XLEN-1];
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU), radix-2
// shift-add on one shared adder. Signed handling (operand and product
// negation states) is built only when MUL_SIGNED_EN is defined; otherwise
// all ops are treated as unsigned.
//
//  state     | meaning
//  ----------+---------------------------------------------------
//  ST_IDLE   | ready for operands
//  ST_NEG_A  | a <= -a (signed multiplicand)
//  ST_NEG_B  | lo <= -lo (signed multiplier)
//  ST_RUN    | 32 shift-add iterations into {hi, lo}
//  ST_NEG_LO | lo <= -lo, keep carry for the high word
//  ST_NEG_HI | hi <= ~hi + carry
//  ST_DONE   | result valid, wait for consumer
module mul_seq_ctrl
  import mul_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  logic [XLEN-1:0]  add_a, add_b, add_sum;
  logic             add_cin, add_cout;

`ifdef MUL_SIGNED_EN
  logic sa_in, sb_in;
  logic sb_q, neg_q, carry_q;

  // Operand sign flags, evaluated on the request inputs.
  always_comb begin
    sa_in = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && a_i[XLEN-1];
    sb_in = (op_i == OP_MULH) && b_i[XLEN-1];
  end
`endif

  assign accept = in_valid_i && (state_q == ST_IDLE) && !flush_i;

  // Shared adder input selection; negation is ~x + cin.
  always_comb begin
    add_a   = hi_q;
    add_b   = lo_q[0] ? a_q : '0;
    add_cin = 1'b0;
    case (state_q)
`ifdef MUL_SIGNED_EN
      ST_NEG_A: begin
        add_a   = ~a_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      ST_NEG_B, ST_NEG_LO: begin
        add_a   = ~lo_q;
        add_b   = '0;
        add_cin = 1'b1;
      end
      ST_NEG_HI: begin
        add_a   = ~hi_q;
        add_b   = '0;
        add_cin = carry_q;
      end
`endif
      default: ;
    endcase
  end

  cla_adder_32 u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/result outputs; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    result_o    = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (accept) begin
`ifdef MUL_SIGNED_EN
          if (sa_in)      state_d = ST_NEG_A;
          else if (sb_in) state_d = ST_NEG_B;
          else            state_d = ST_RUN;
`else
          state_d = ST_RUN;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      ST_NEG_A:  state_d = sb_q ? ST_NEG_B : ST_RUN;
      ST_NEG_B:  state_d = ST_RUN;
      ST_NEG_LO: state_d = ST_NEG_HI;
      ST_NEG_HI: state_d = ST_DONE;
      ST_RUN: begin
        if (cnt_q == CNT_LAST) state_d = neg_q ? ST_NEG_LO : ST_DONE;
      end
`else
      ST_RUN: begin
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        out_valid_o = 1'b1;
        result_o    = (op_q == OP_MUL) ? lo_q : hi_q;
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Datapath registers: operand capture, shift-add steps and negations.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= OP_MUL;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`ifdef MUL_SIGNED_EN
      sb_q    <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op_i;
            a_q   <= a_i;
            lo_q  <= b_i;
            hi_q  <= '0;
            cnt_q <= '0;
`ifdef MUL_SIGNED_EN
            sb_q  <= sb_in;
            neg_q <= sa_in ^ sb_in;
`endif
          end
        end
        ST_RUN: begin
          hi_q  <= {add_cout, add_sum[XLEN-1:1]};
          lo_q  <= {add_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q + 5'd1;
        end
`ifdef MUL_SIGNED_EN
        ST_NEG_A:  a_q  <= add_sum;
        ST_NEG_B:  lo_q <= add_sum;
        ST_NEG_LO: begin
          lo_q    <= add_sum;
          carry_q <= add_cout;
        end
        ST_NEG_HI: hi_q <= add_sum;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed cases, flush/reset aborts,
// back-pressure and randomized ops checked against a 64-bit product model.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mul_seq_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic op_sa(input logic [1:0] op, input logic [31:0] a);
    return SIGNED_EN && ((op == OP_MULH) || (op == OP_MULHSU)) && a[31];
  endfunction

  function automatic logic op_sb(input logic [1:0] op, input logic [31:0] b);
    return SIGNED_EN && (op == OP_MULH) && b[31];
  endfunction

  // Full 64-bit product of the (possibly sign-extended) operands.
  function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] wa, wb, prod;
    wa   = op_sa(op, a) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    wb   = op_sb(op, b) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    prod = wa * wb;
    return (op == OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    int sa, sb;
    sa = op_sa(op, a) ? 1 : 0;
    sb = op_sb(op, b) ? 1 : 0;
    return 33 + sa + sb + 2 * (sa ^ sb);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op, measure latency, hold DONE for 'hold' cycles, then hand off.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    int lat;
    logic [31:0] exp_res;
    exp_res     = model_result(op, a, b);
    out_ready_i = (hold == 0);
    check_val("ready_before", {31'b0, in_ready_o}, 32'd1);
    op_i       = op;
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    a_i        = $urandom;
    b_i        = $urandom;
    op_i       = 2'($urandom_range(0, 3));
    check_val("ready_busy", {31'b0, in_ready_o}, 32'd0);
    lat = 1;
    while (!out_valid_o && lat < 80) begin
      step();
      lat++;
    end
    check_val("latency", lat, model_latency(op, a, b));
    check_val("result", result_o, exp_res);
    for (int h = 0; h < hold; h++) begin
      in_valid_i = 1'b1;
      step();
      check_val("bp_valid", {31'b0, out_valid_o}, 32'd1);
      check_val("bp_result", result_o, exp_res);
      check_val("bp_ready", {31'b0, in_ready_o}, 32'd0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    check_val("valid_after", {31'b0, out_valid_o}, 32'd0);
    check_val("ready_after", {31'b0, in_ready_o}, 32'd1);
  endtask

  // Start an unsigned op and abort it at RUN iteration 10 via flush or reset.
  task automatic abort_op(input bit use_rst);
    logic seen;
    out_ready_i = 1'b1;
    op_i       = OP_MULHU;
    a_i        = 32'h1234_5678;
    b_i        = 32'h9ABC_DEF0;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    repeat (10) step();
    if (use_rst) rst_i = 1'b1;
    else         flush_i = 1'b1;
    step();
    rst_i   = 1'b0;
    flush_i = 1'b0;
    check_val("abort_ready", {31'b0, in_ready_o}, 32'd1);
    check_val("abort_valid", {31'b0, out_valid_o}, 32'd0);
    check_val("abort_result", result_o, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (out_valid_o) seen = 1'b1;
    end
    check_val("abort_no_result", {31'b0, seen}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    op_i        = OP_MUL;
    a_i         = '0;
    b_i         = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) step();
    check_val("rst_ready", {31'b0, in_ready_o}, 32'd1);
    check_val("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check_val("rst_result", result_o, 32'd0);
    rst_i = 1'b0;
    step();

    run_op(OP_MUL,    32'd7,        32'd6,        0);
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 0);
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULH,   32'h0000_0003, 32'hFFFF_FFFB, 0);
    run_op(OP_MUL,    32'h1234_5678, 32'h0000_0010, 5);

    abort_op(1'b0);
    run_op(OP_MULH, 32'hFFFF_FFF0, 32'h0000_0100, 0);
    abort_op(1'b1);
    run_op(OP_MULHSU, 32'h8000_0001, 32'h7FFF_FFFF, 1);

    // Flush concurrent with a request in IDLE: nothing is accepted.
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    step();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    check_val("idle_flush_ready", {31'b0, in_ready_o}, 32'd1);

    // Flush while the result is waiting in DONE drops it.
    out_ready_i = 1'b0;
    op_i        = OP_MULHU;
    a_i         = 32'd5;
    b_i         = 32'd9;
    in_valid_i  = 1'b1;
    step();
    in_valid_i = 1'b0;
    begin
      int lat;
      lat = 1;
      while (!out_valid_o && lat < 80) begin
        step();
        lat++;
      end
      check_val("done_flush_lat", lat, 33);
    end
    flush_i = 1'b1;
    step();
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
    check_val("done_flush_valid", {31'b0, out_valid_o}, 32'd0);
    check_val("done_flush_ready", {31'b0, in_ready_o}, 32'd1);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
